// File: rtl/usb_poll_pkg.sv
// Shared constants for the USB poll scheduler: state encoding and default sizing.
package usb_poll_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SCAN = 3'd1;
  localparam logic [2:0] ST_SEND = 3'd2;
  localparam logic [2:0] ST_GAP  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam int NCH_DEF = 8;
  localparam int TMO_DEF = 1023;
  localparam int TW_DEF  = 10;

endpackage

// File: rtl/usb_poll_pick.sv
// Lowest-set-bit encoder: idx is the index of the lowest set bit of vec,
// any flags that at least one bit is set (idx is 0 when vec is empty).
module usb_poll_pick
  import usb_poll_pkg::*;
#(
  parameter int NCH = NCH_DEF
) (
  input  logic [NCH-1:0] vec,
  output logic [2:0]     idx,
  output logic           any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = 3'd0;
    any = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      idx = vec[i] ? 3'(i) : idx;
      any = any | vec[i];
    end
  end

endmodule

// File: rtl/usb_poll_sched.sv
// USB poll scheduler: on each accepted start, serves the latched enabled
// channels lowest-index first, one send engine at a time, and reports which
// channels failed or timed out. Optional feature macro: USB_POLL_RETRY_EN
// (re-issue a failed/timed-out channel once; only the second outcome counts).
module usb_poll_sched
  import usb_poll_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int TMO = TMO_DEF,
  parameter int TW  = TW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [NCH-1:0] chan_en,
  output logic [NCH-1:0] fs_usb_send,
  input  logic [NCH-1:0] fd_usb_send,
  input  logic [NCH-1:0] ff_usb_send,
  output logic           busy,
  output logic           done,
  output logic [NCH-1:0] fail_mask,
  output logic [2:0]     cur_chan,
  output logic           overrun
);

  localparam logic [TW-1:0] TMO_CNT = TW'(TMO);

  logic [2:0]     state;
  logic [NCH-1:0] pend;
  logic [NCH-1:0] fail_acc;
  logic [TW-1:0]  tmo;
  logic [2:0]     pick_idx;
  logic           pick_any;
  logic           resp_fd;
  logic           resp_ff;
  logic           tmo_hit;
`ifdef USB_POLL_RETRY_EN
  logic           retry;
`endif

  usb_poll_pick #(.NCH(NCH)) u_pick (
    .vec (pend),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Only the channel being served may end the SEND phase; ff beats fd.
  always_comb begin
    resp_ff = ff_usb_send[cur_chan];
    resp_fd = fd_usb_send[cur_chan];
    tmo_hit = (tmo == TMO_CNT);
  end

  // Round sequencer: latch the channel set, serve each channel, report.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      pend        <= '0;
      fail_acc    <= '0;
      tmo         <= '0;
      fs_usb_send <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fail_mask   <= '0;
      cur_chan    <= 3'd0;
`ifdef USB_POLL_RETRY_EN
      retry       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            pend     <= chan_en;
            fail_acc <= '0;
            busy     <= 1'b1;
`ifdef USB_POLL_RETRY_EN
            retry    <= 1'b0;
`endif
            state    <= ST_SCAN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SCAN: begin
          if (!pick_any) begin
            state <= ST_DONE;
          end else begin
            cur_chan    <= pick_idx;
            fs_usb_send <= NCH'(1) << pick_idx;
            tmo         <= '0;
            state       <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (resp_ff || (!resp_fd && tmo_hit)) begin
            // Failure or timeout.
`ifdef USB_POLL_RETRY_EN
            if (!retry) begin
              retry <= 1'b1;
            end else begin
              retry              <= 1'b0;
              fail_acc[cur_chan] <= 1'b1;
              pend[cur_chan]     <= 1'b0;
            end
`else
            fail_acc[cur_chan] <= 1'b1;
            pend[cur_chan]     <= 1'b0;
`endif
            fs_usb_send <= '0;
            state       <= ST_GAP;
          end else if (resp_fd) begin
            pend[cur_chan] <= 1'b0;
`ifdef USB_POLL_RETRY_EN
            retry          <= 1'b0;
`endif
            fs_usb_send    <= '0;
            state          <= ST_GAP;
          end else begin
            tmo <= tmo_hit ? tmo : tmo + TW'(1);
          end
        end
        ST_GAP: begin
          state <= ST_SCAN;
        end
        ST_DONE: begin
          done      <= 1'b1;
          fail_mask <= fail_acc;
          busy      <= 1'b0;
          cur_chan  <= 3'd0;
          state     <= ST_IDLE;
        end
        default: begin
          fs_usb_send <= '0;
          busy        <= 1'b0;
          cur_chan    <= 3'd0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky flag for a start request that arrived while a round was running.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (start && (state != ST_IDLE)) begin
      overrun <= 1'b1;
    end else begin
      overrun <= overrun;
    end
  end

endmodule

// File: tb/tb_usb_poll_sched.sv
// Self-checking bench for usb_poll_sched: directed table, directed corner
// sequences (overrun, reset mid-send) and random rounds against a round model.
module tb_usb_poll_sched;

  localparam int NCH = 8;
  localparam int TMO = 15;
  localparam int TW  = 4;
`ifdef USB_POLL_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] chan_en;
  logic [7:0] fs;
  logic [7:0] fd;
  logic [7:0] ff;
  logic       busy;
  logic       done;
  logic [7:0] fail_mask;
  logic [2:0] cur_chan;
  logic       overrun;

  usb_poll_sched #(.NCH(NCH), .TMO(TMO), .TW(TW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .chan_en     (chan_en),
    .fs_usb_send (fs),
    .fd_usb_send (fd),
    .ff_usb_send (ff),
    .busy        (busy),
    .done        (done),
    .fail_mask   (fail_mask),
    .cur_chan    (cur_chan),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Expected round: list of send attempts (channel, cycles fs high), mask, latency.
  int         m_chan[$];
  int         m_dur[$];
  logic [7:0] m_mask;
  int         m_lat;

  // kinds: 2 bits per channel, bit0 = pulse fd, bit1 = pulse ff, 0 = never answers.
  // dly: cycles after fs rises that the engine answers.
  task automatic model(input logic [7:0] en, input logic [15:0] kinds, input int dly);
    int  k;
    bit  ok;
    int  dur;
    int  tries;
    m_chan.delete();
    m_dur.delete();
    m_mask = 8'h00;
    m_lat  = 1;
    for (int i = 0; i < 8; i++) begin
      if (en[i]) begin
        k     = int'(kinds[2*i +: 2]);
        ok    = (k == 1) && (dly <= TMO);
        dur   = ((k == 0) || (dly > TMO)) ? TMO + 1 : dly + 1;
        tries = (!ok && RETRY) ? 2 : 1;
        for (int a = 0; a < tries; a++) begin
          m_chan.push_back(i);
          m_dur.push_back(dur);
          m_lat += dur + 2;
        end
        if (!ok) m_mask[i] = 1'b1;
      end
    end
    m_lat += 2;
  endtask

  // Observed round.
  int         o_chan[$];
  int         o_dur[$];
  int         o_lat;
  logic [7:0] o_mask;
  int         o_busy_err;
  int         o_oh_err;
  int         o_cur_err;
  int         o_hold_err;
  logic [7:0] prev_mask = 8'h00;

  // Issues one round starting at a negedge and plays the send engines.
  task automatic run_round(input logic [7:0] en, input logic [15:0] kinds, input int dly,
                           input int ovr_at, input bit noise);
    int         age;
    int         pdur;
    int         k;
    logic [7:0] pfs;
    o_chan.delete();
    o_dur.delete();
    o_lat = -1;
    o_mask = 8'hxx;
    o_busy_err = 0; o_oh_err = 0; o_cur_err = 0; o_hold_err = 0;
    age = 0; pdur = 0; pfs = 8'h00;
    chan_en = en;
    start = 1'b1;
    for (int t = 1; t <= 3000; t++) begin
      @(negedge clk);
      start   = (t == ovr_at);
      chan_en = 8'($urandom);
      if ($countones(fs) > 1) o_oh_err++;
      if (fs != 8'h00) begin
        if (pfs == 8'h00) begin age = 0; pdur = 1; end
        else begin age++; pdur++; end
        if (int'(cur_chan) != onehot_idx(fs)) o_cur_err++;
      end else if (pfs != 8'h00) begin
        o_chan.push_back(onehot_idx(pfs));
        o_dur.push_back(pdur);
      end
      if (done) begin
        o_lat  = t;
        o_mask = fail_mask;
        if (busy) o_busy_err++;
        if (cur_chan != 3'd0) o_cur_err++;
        break;
      end
      if (!busy) o_busy_err++;
      if (fail_mask !== prev_mask) o_hold_err++;
      fd = noise ? 8'($urandom) : 8'h00;
      ff = noise ? 8'($urandom) : 8'h00;
      if (fs != 8'h00) begin
        k = onehot_idx(fs);
        fd[k] = (age == dly) ? kinds[2*k]     : 1'b0;
        ff[k] = (age == dly) ? kinds[2*k + 1] : 1'b0;
      end
      pfs = fs;
    end
    start = 1'b0;
    fd = 8'h00;
    ff = 8'h00;
  endtask

  task automatic check_round(input string tag);
    check({tag, ".latency"}, 32'(o_lat), 32'(m_lat));
    check({tag, ".fail_mask"}, {24'h0, o_mask}, {24'h0, m_mask});
    check({tag, ".sends"}, 32'(o_chan.size()), 32'(m_chan.size()));
    for (int i = 0; i < o_chan.size() && i < m_chan.size(); i++) begin
      check({tag, ".send_chan"}, 32'(o_chan[i]), 32'(m_chan[i]));
      check({tag, ".send_len"},  32'(o_dur[i]),  32'(m_dur[i]));
    end
    check({tag, ".onehot_err"}, 32'(o_oh_err),   32'd0);
    check({tag, ".curchan_err"}, 32'(o_cur_err), 32'd0);
    check({tag, ".busy_err"},   32'(o_busy_err), 32'd0);
    check({tag, ".hold_err"},   32'(o_hold_err), 32'd0);
    prev_mask = m_mask;
    @(negedge clk);
    check({tag, ".done_1cyc"}, {31'h0, done}, 32'd0);
  endtask

  typedef struct {
    logic [7:0]  en;
    logic [15:0] kinds;
    int          dly;
    logic [7:0]  exp_mask;
    int          exp_lat;
    int          exp_lat_r;
  } vec_t;

  vec_t tbl[8];
  int   done_cnt;

  initial begin
    tbl[0] = '{8'h00, 16'h0000, 0,  8'h00, 3,  3};
    tbl[1] = '{8'h25, 16'h5555, 4,  8'h00, 24, 24};
    tbl[2] = '{8'h03, 16'h0001, 4,  8'h02, 28, 46};
    tbl[3] = '{8'h01, 16'h0003, 4,  8'h01, 10, 17};
    tbl[4] = '{8'h81, 16'h4002, 0,  8'h01, 9,  12};
    tbl[5] = '{8'hFF, 16'h5555, 0,  8'h00, 27, 27};
    tbl[6] = '{8'h10, 16'h0200, 15, 8'h10, 21, 39};
    tbl[7] = '{8'h10, 16'h0100, 15, 8'h00, 21, 21};

    rst = 1'b1; start = 1'b0; chan_en = 8'h00; fd = 8'h00; ff = 8'h00;
    repeat (3) @(negedge clk);
    check("reset.fs",        {24'h0, fs},        32'd0);
    check("reset.busy",      {31'h0, busy},      32'd0);
    check("reset.done",      {31'h0, done},      32'd0);
    check("reset.fail_mask", {24'h0, fail_mask}, 32'd0);
    check("reset.cur_chan",  {29'h0, cur_chan},  32'd0);
    check("reset.overrun",   {31'h0, overrun},   32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      model(tbl[i].en, tbl[i].kinds, tbl[i].dly);
      run_round(tbl[i].en, tbl[i].kinds, tbl[i].dly, 0, i >= 2);
      check("tbl.exp_mask", {24'h0, o_mask}, {24'h0, tbl[i].exp_mask});
      check("tbl.exp_lat", 32'(o_lat), 32'(RETRY ? tbl[i].exp_lat_r : tbl[i].exp_lat));
      check_round("tbl");
    end
    check("overrun.before", {31'h0, overrun}, 32'd0);

    // Start repeated mid-round: ignored, flags overrun.
    model(8'h25, 16'h5555, 4);
    run_round(8'h25, 16'h5555, 4, 5, 1'b1);
    check_round("ovr");
    check("overrun.set", {31'h0, overrun}, 32'd1);

    // Random rounds against the model.
    for (int r = 0; r < 40; r++) begin
      logic [7:0]  en;
      logic [15:0] kinds;
      int          dly;
      en    = 8'($urandom);
      kinds = 16'($urandom);
      dly   = int'($urandom_range(0, 18));
      model(en, kinds, dly);
      run_round(en, kinds, dly, 0, 1'b1);
      check_round("rand");
    end
    check("overrun.sticky", {31'h0, overrun}, 32'd1);

    // Reset in the middle of a send: fs drops, round abandoned, no done.
    chan_en = 8'h01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rstsend.fs_before", {24'h0, fs}, 32'h01);
    rst = 1'b1;
    @(negedge clk);
    check("rstsend.fs",        {24'h0, fs},        32'd0);
    check("rstsend.busy",      {31'h0, busy},      32'd0);
    check("rstsend.done",      {31'h0, done},      32'd0);
    check("rstsend.overrun",   {31'h0, overrun},   32'd0);
    check("rstsend.fail_mask", {24'h0, fail_mask}, 32'd0);
    rst = 1'b0;
    done_cnt = 0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (done || busy || fs != 8'h00) done_cnt++;
    end
    check("rstsend.quiet", 32'(done_cnt), 32'd0);
    prev_mask = 8'h00;

    // Recovery round after reset.
    model(8'h03, 16'h0001, 4);
    run_round(8'h03, 16'h0001, 4, 0, 1'b1);
    check_round("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
